// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and widths for the pipeline hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        LD_HOLD = 1'b1
    } hz_state_e;

    localparam int STALL_CNT_W = 16;
    localparam int MD_CNT_W    = $clog2(64);

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/md_busy_counter.sv
`default_nettype none
// ============================================================================
// Module      : md_busy_counter
// Description : Mult/div occupancy counter; busy while the count is non-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic Clk,
    input  logic Rst,
    input  logic start_i,
    output logic busy_o
);

    localparam logic [MD_CNT_W-1:0] c_LOAD = MD_CNT_W'(MD_CYCLES - 1);

    logic [MD_CNT_W-1:0] cnt_q;
    logic [MD_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = c_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule : md_busy_counter
`default_nettype wire

// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit_mc
// Description : ID-stage hazard unit: load-use, branch-in-ID, mult/div
//               interlock, taken-branch flush and stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int LOAD_STALLS = 1,
    parameter int MD_CYCLES   = 32,
    parameter int ZERO_SKIP   = 1
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [REG_W-1:0]       IDRs,
    input  logic [REG_W-1:0]       IDRt,
    input  logic                   IDUsesRs,
    input  logic                   IDUsesRt,
    input  logic                   IDIsBranch,
    input  logic                   IDBranchTaken,
    input  logic                   IDIsMD,
    input  logic                   IDReadsHiLo,
    input  logic [REG_W-1:0]       EXRd,
    input  logic                   EXRegWrite,
    input  logic                   EXMemRead,
    input  logic [REG_W-1:0]       MEMRd,
    input  logic                   MEMMemRead,
    output logic                   PCWrite,
    output logic                   IFIDWrite,
    output logic                   IDEXBubble,
    output logic                   IFIDFlush,
    output logic                   MDBusy,
    output logic [STALL_CNT_W-1:0] StallCount
);

    localparam int         c_HOLD_INIT_I = (LOAD_STALLS > 1) ? (LOAD_STALLS - 2) : 0;
    localparam logic [1:0] c_HOLD_INIT   = 2'(c_HOLD_INIT_I);

    hz_state_e              state_q, state_d;
    logic [1:0]             hold_q, hold_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic w_ex_match, w_mem_match;
    logic w_load_use, w_br_hz, w_md_hz;
    logic w_stall, w_md_start;

    function automatic logic f_match(
        input logic [REG_W-1:0] r,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             uses_rs,
        input logic             uses_rt
    );
        return ((r != '0) || (ZERO_SKIP == 0)) &&
               ((uses_rs && (rs == r)) || (uses_rt && (rt == r)));
    endfunction

    assign w_ex_match  = f_match(EXRd,  IDRs, IDRt, IDUsesRs, IDUsesRt);
    assign w_mem_match = f_match(MEMRd, IDRs, IDRt, IDUsesRs, IDUsesRt);
    assign w_load_use  = EXMemRead && w_ex_match;
    assign w_br_hz     = IDIsBranch && ((EXRegWrite && w_ex_match) ||
                                        (MEMMemRead && w_mem_match));
    assign w_md_hz     = MDBusy && (IDIsMD || IDReadsHiLo);

    // State register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (w_load_use && (LOAD_STALLS > 1)) begin
                    state_d = LD_HOLD;
                    hold_d  = c_HOLD_INIT;
                end
            end
            LD_HOLD: begin
                if (hold_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // Output logic: LD_HOLD stalls unconditionally, IDLE stalls on any hazard
    always_comb begin
        w_stall = 1'b0;
        case (state_q)
            IDLE:    w_stall = w_load_use || w_br_hz || w_md_hz;
            LD_HOLD: w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
        PCWrite    = !w_stall;
        IFIDWrite  = !w_stall;
        IDEXBubble = w_stall;
        IFIDFlush  = IDIsBranch && IDBranchTaken && !w_stall;
    end

    assign w_md_start = (state_q == IDLE) && IDIsMD && !w_stall && !MDBusy;

    md_busy_counter #(
        .MD_CYCLES (MD_CYCLES)
    ) u_md_busy (
        .Clk     (Clk),
        .Rst     (Rst),
        .start_i (w_md_start),
        .busy_o  (MDBusy)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;

endmodule : hazard_unit_mc
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit_mc
// Description : Directed bench; dut_a uses LOAD_STALLS=1/ZERO_SKIP=1,
//               dut_b uses LOAD_STALLS=3/ZERO_SKIP=0, both MD_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit_mc;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [4:0] IDRs, IDRt, EXRd, MEMRd;
    logic       IDUsesRs, IDUsesRt, IDIsBranch, IDBranchTaken, IDIsMD, IDReadsHiLo;
    logic       EXRegWrite, EXMemRead, MEMMemRead;

    logic        PCWrite_a, IFIDWrite_a, IDEXBubble_a, IFIDFlush_a, MDBusy_a;
    logic        PCWrite_b, IFIDWrite_b, IDEXBubble_b, IFIDFlush_b, MDBusy_b;
    logic [15:0] StallCount_a, StallCount_b;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    hazard_unit_mc #(.REG_W(5), .LOAD_STALLS(1), .MD_CYCLES(4), .ZERO_SKIP(1)) dut_a (
        .Clk(Clk), .Rst(Rst), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
        .IDIsBranch(IDIsBranch), .IDBranchTaken(IDBranchTaken), .IDIsMD(IDIsMD),
        .IDReadsHiLo(IDReadsHiLo), .EXRd(EXRd), .EXRegWrite(EXRegWrite), .EXMemRead(EXMemRead),
        .MEMRd(MEMRd), .MEMMemRead(MEMMemRead), .PCWrite(PCWrite_a), .IFIDWrite(IFIDWrite_a),
        .IDEXBubble(IDEXBubble_a), .IFIDFlush(IFIDFlush_a), .MDBusy(MDBusy_a),
        .StallCount(StallCount_a));

    hazard_unit_mc #(.REG_W(5), .LOAD_STALLS(3), .MD_CYCLES(4), .ZERO_SKIP(0)) dut_b (
        .Clk(Clk), .Rst(Rst), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
        .IDIsBranch(IDIsBranch), .IDBranchTaken(IDBranchTaken), .IDIsMD(IDIsMD),
        .IDReadsHiLo(IDReadsHiLo), .EXRd(EXRd), .EXRegWrite(EXRegWrite), .EXMemRead(EXMemRead),
        .MEMRd(MEMRd), .MEMMemRead(MEMMemRead), .PCWrite(PCWrite_b), .IFIDWrite(IFIDWrite_b),
        .IDEXBubble(IDEXBubble_b), .IFIDFlush(IFIDFlush_b), .MDBusy(MDBusy_b),
        .StallCount(StallCount_b));

    wire [3:0] ctl_a = {PCWrite_a, IFIDWrite_a, IDEXBubble_a, IFIDFlush_a};
    wire [3:0] ctl_b = {PCWrite_b, IFIDWrite_b, IDEXBubble_b, IFIDFlush_b};

    typedef struct {
        logic [4:0] rs, rt;
        logic       urs, urt, br, tk;
        logic [4:0] exrd;
        logic       exrw, exmr;
        logic [4:0] memrd;
        logic       memmr;
        logic       sa, fa, sb, fb;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [3:0] exp_ctl(input logic s, input logic f);
        return {~s, ~s, s, f};
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic clr_in();
        IDRs = '0; IDRt = '0; IDUsesRs = 0; IDUsesRt = 0; IDIsBranch = 0; IDBranchTaken = 0;
        IDIsMD = 0; IDReadsHiLo = 0; EXRd = '0; EXRegWrite = 0; EXMemRead = 0;
        MEMRd = '0; MEMMemRead = 0;
    endtask

    // Pulse reset inside the low clock phase; returns before the next rising edge
    task automatic pulse_reset();
        @(negedge Clk);
        Rst = 1'b0;
        #2;
        Rst = 1'b1;
        #1;
    endtask

    initial begin
        Rst = 1'b0;
        clr_in();
        //        rs  rt urs urt br tk exrd rw mr memrd mm  sa fa sb fb
        vecs[0]  = '{5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0};
        vecs[1]  = '{5'd8, 5'd0, 1, 0, 0, 0, 5'd8, 1, 1, 5'd0, 0, 1, 0, 1, 0};
        vecs[2]  = '{5'd8, 5'd0, 0, 0, 0, 0, 5'd8, 1, 1, 5'd0, 0, 0, 0, 0, 0};
        vecs[3]  = '{5'd2, 5'd8, 1, 1, 0, 0, 5'd8, 1, 1, 5'd0, 0, 1, 0, 1, 0};
        vecs[4]  = '{5'd9, 5'd0, 1, 0, 0, 0, 5'd9, 1, 0, 5'd0, 0, 0, 0, 0, 0};
        vecs[5]  = '{5'd9, 5'd0, 1, 0, 1, 1, 5'd9, 1, 0, 5'd0, 0, 1, 0, 1, 0};
        vecs[6]  = '{5'd4, 5'd9, 1, 1, 1, 0, 5'd0, 0, 0, 5'd9, 1, 1, 0, 1, 0};
        vecs[7]  = '{5'd9, 5'd0, 1, 0, 1, 1, 5'd3, 1, 0, 5'd0, 0, 0, 1, 0, 1};
        vecs[8]  = '{5'd9, 5'd0, 1, 0, 1, 0, 5'd3, 1, 0, 5'd0, 0, 0, 0, 0, 0};
        vecs[9]  = '{5'd0, 5'd0, 1, 0, 0, 0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 1, 0};
        vecs[10] = '{5'd0, 5'd0, 1, 0, 1, 1, 5'd0, 1, 0, 5'd0, 0, 0, 1, 1, 0};
        vecs[11] = '{5'd9, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0, 5'd9, 1, 0, 0, 0, 0};

        // Reset state with idle inputs
        pulse_reset();
        chk("reset_ctl_a", 0, 32'(ctl_a), 32'(exp_ctl(0, 0)));
        chk("reset_md_a", 0, 32'(MDBusy_a), 32'd0);
        chk("reset_cnt_a", 0, 32'(StallCount_a), 32'd0);

        // Combinational table, each vector from a freshly reset IDLE state
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            Rst = 1'b0;
            IDRs = vecs[i].rs; IDRt = vecs[i].rt; IDUsesRs = vecs[i].urs; IDUsesRt = vecs[i].urt;
            IDIsBranch = vecs[i].br; IDBranchTaken = vecs[i].tk;
            EXRd = vecs[i].exrd; EXRegWrite = vecs[i].exrw; EXMemRead = vecs[i].exmr;
            MEMRd = vecs[i].memrd; MEMMemRead = vecs[i].memmr;
            #2;
            Rst = 1'b1;
            #1;
            chk("tbl_ctl_a", i, 32'(ctl_a), 32'(exp_ctl(vecs[i].sa, vecs[i].fa)));
            chk("tbl_ctl_b", i, 32'(ctl_b), 32'(exp_ctl(vecs[i].sb, vecs[i].fb)));
        end

        // Load-use: 1 stall on dut_a, 3 on dut_b
        clr_in();
        pulse_reset();
        IDRs = 5'd8; IDUsesRs = 1; EXRd = 5'd8; EXRegWrite = 1; EXMemRead = 1;
        #1;
        chk("lu_c0_a", 0, 32'(ctl_a), 32'(exp_ctl(1, 0)));
        chk("lu_c0_b", 0, 32'(ctl_b), 32'(exp_ctl(1, 0)));
        chk("lu_cnt0_a", 0, 32'(StallCount_a), 32'd0);
        @(posedge Clk); #1;
        clr_in();
        @(negedge Clk);
        chk("lu_c1_a", 1, 32'(ctl_a), 32'(exp_ctl(0, 0)));
        chk("lu_cnt1_a", 1, 32'(StallCount_a), 32'd1);
        chk("lu_c1_b", 1, 32'(ctl_b), 32'(exp_ctl(1, 0)));
        @(negedge Clk);
        chk("lu_c2_b", 2, 32'(ctl_b), 32'(exp_ctl(1, 0)));
        @(negedge Clk);
        chk("lu_c3_b", 3, 32'(ctl_b), 32'(exp_ctl(0, 0)));
        chk("lu_cnt3_b", 3, 32'(StallCount_b), 32'd3);
        chk("lu_cnt3_a", 3, 32'(StallCount_a), 32'd1);

        // Branch behind a load on dut_a: two stalls, then taken flush
        clr_in();
        pulse_reset();
        IDRs = 5'd9; IDUsesRs = 1; IDIsBranch = 1; IDBranchTaken = 1;
        EXRd = 5'd9; EXRegWrite = 1; EXMemRead = 1;
        #1;
        chk("blw_c0_a", 0, 32'(ctl_a), 32'(exp_ctl(1, 0)));
        @(posedge Clk); #1;
        EXRd = '0; EXRegWrite = 0; EXMemRead = 0; MEMRd = 5'd9; MEMMemRead = 1;
        @(negedge Clk);
        chk("blw_c1_a", 1, 32'(ctl_a), 32'(exp_ctl(1, 0)));
        @(posedge Clk); #1;
        MEMRd = '0; MEMMemRead = 0;
        @(negedge Clk);
        chk("blw_c2_a", 2, 32'(ctl_a), 32'(exp_ctl(0, 1)));
        chk("blw_cnt_a", 2, 32'(StallCount_a), 32'd2);

        // mult then mflo: 3 stalled cycles while busy, issue on the 4th
        clr_in();
        pulse_reset();
        IDIsMD = 1;
        #1;
        chk("md_start_ctl_a", 0, 32'(ctl_a), 32'(exp_ctl(0, 0)));
        chk("md_start_busy_a", 0, 32'(MDBusy_a), 32'd0);
        @(posedge Clk); #1;
        IDIsMD = 0; IDReadsHiLo = 1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge Clk);
            chk("md_busy_a", c, 32'(MDBusy_a), (c < 4) ? 32'd1 : 32'd0);
            chk("md_ctl_a", c, 32'(ctl_a), 32'(exp_ctl((c < 4), 0)));
        end
        chk("md_cnt_a", 4, 32'(StallCount_a), 32'd3);

        // Async reset while dut_b is in LD_HOLD and the mult/div is busy
        clr_in();
        pulse_reset();
        IDIsMD = 1;
        @(posedge Clk); #1;
        IDIsMD = 0;
        IDRs = 5'd8; IDUsesRs = 1; EXRd = 5'd8; EXRegWrite = 1; EXMemRead = 1;
        @(posedge Clk); #1;
        clr_in();
        @(negedge Clk);
        chk("rst_pre_ctl_b", 0, 32'(ctl_b), 32'(exp_ctl(1, 0)));
        chk("rst_pre_busy_b", 0, 32'(MDBusy_b), 32'd1);
        Rst = 1'b0;
        #1;
        chk("rst_ctl_b", 1, 32'(ctl_b), 32'(exp_ctl(0, 0)));
        chk("rst_busy_b", 1, 32'(MDBusy_b), 32'd0);
        chk("rst_cnt_b", 1, 32'(StallCount_b), 32'd0);
        #1;
        Rst = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        chk("post_ctl_b", 2, 32'(ctl_b), 32'(exp_ctl(0, 0)));
        chk("post_cnt_b", 2, 32'(StallCount_b), 32'd0);
        chk("post_busy_b", 2, 32'(MDBusy_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_hazard_unit_mc
`default_nettype wire
